// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, sequencer states,
// memory address select codes and the instruction class bundle.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_PC1 = 2'd1;
  localparam logic [1:0] SEL_IR  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_OPER,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic needs_mem;
    logic two_byte;
    logic is_halt;
    logic is_jump;
  } instr_class_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle of signals between the sequencer and the memory, PC and accumulator
// datapath. The sequencer is the master; the datapath side is the slave.
interface control_sequencer_if;
  import cpu_pkg::*;

  logic              run;
  logic [DATA_W-1:0] mem_rdata;
  logic              z_flag;
  logic              c_flag;
  logic              pc_inc;
  logic              pc_skip;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_data;
  logic [1:0]        mem_addr_sel;
  logic              mem_rd;
  logic              mem_wr;
  logic              acc_load;
  logic              acc_src;
  logic              alu_sub;
  logic              out_load;
  logic [DATA_W-1:0] ir;
  logic              halted;

  modport master (
    input  run, mem_rdata, z_flag, c_flag,
    output pc_inc, pc_skip, pc_load, pc_data, mem_addr_sel, mem_rd, mem_wr,
           acc_load, acc_src, alu_sub, out_load, ir, halted
  );

  modport slave (
    output run, mem_rdata, z_flag, c_flag,
    input  pc_inc, pc_skip, pc_load, pc_data, mem_addr_sel, mem_rd, mem_wr,
           acc_load, acc_src, alu_sub, out_load, ir, halted
  );

endinterface

// File: rtl/control_sequencer_instr_decode.sv
// Opcode classifier: maps an opcode to the class bits that steer the
// sequencer's path through MEM/OPER and its EXEC behaviour.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0]   opcode,
  output instr_class_t cls
);

  always_comb begin
    cls = '0;
    unique case (opcode)
      OP_LDA, OP_ADD, OP_SUB: cls.needs_mem = 1'b1;
      OP_LDI:                 cls.two_byte  = 1'b1;
      OP_HLT:                 cls.is_halt   = 1'b1;
      OP_JMP, OP_JZ, OP_JC:   cls.is_jump   = 1'b1;
      default:                cls = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns the instruction register and
// drives PC, memory, accumulator and output-register controls as Moore outputs.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.master bus
);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] ir_q;
  logic [3:0]        dec_op;
  instr_class_t      cls;
  logic              take;

  // In DECODE the instruction is still on mem_rdata; afterwards it lives in ir_q.
  assign dec_op = (state == ST_DECODE) ? bus.mem_rdata[7:4] : ir_q[7:4];

  instr_decode u_decode (
    .opcode (dec_op),
    .cls    (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
      ir_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state <= state_next;
      if (state == ST_DECODE) ir_q <= bus.mem_rdata;
    end
  end

  assign bus.ir      = ir_q;
  assign bus.pc_data = ir_q[ADDR_W-1:0];

  always_comb begin
    // NOTE: every output defaulted first so no path through the case infers a latch.
    state_next       = state;
    take             = 1'b0;
    bus.pc_inc       = 1'b0;
    bus.pc_skip      = 1'b0;
    bus.pc_load      = 1'b0;
    bus.mem_addr_sel = SEL_PC;
    bus.mem_rd       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.acc_load     = 1'b0;
    bus.acc_src      = 1'b0;
    bus.alu_sub      = 1'b0;
    bus.out_load     = 1'b0;
    bus.halted       = 1'b0;

    // Outputs are forced quiet while reset is held, even though state is FETCH.
    if (!reset) begin
      unique case (state)
        ST_FETCH: begin
          if (bus.run) begin
            bus.mem_rd = 1'b1;
            state_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (cls.is_halt)        state_next = ST_HALT;
          else if (cls.needs_mem) state_next = ST_MEM;
          else if (cls.two_byte)  state_next = ST_OPER;
          else                    state_next = ST_EXEC;
        end
        ST_MEM: begin
          bus.mem_rd       = 1'b1;
          bus.mem_addr_sel = SEL_IR;
          state_next       = ST_EXEC;
        end
        ST_OPER: begin
          bus.mem_rd       = 1'b1;
          bus.mem_addr_sel = SEL_PC1;
          state_next       = ST_EXEC;
        end
        ST_EXEC: begin
          state_next = ST_FETCH;
          if (cls.needs_mem) begin
            bus.acc_load = 1'b1;
            bus.acc_src  = (dec_op == OP_LDA);
            bus.alu_sub  = (dec_op == OP_SUB);
            bus.pc_inc   = 1'b1;
          end else if (cls.two_byte) begin
            bus.acc_load = 1'b1;
            bus.acc_src  = 1'b1;
            bus.pc_skip  = 1'b1;
          end else if (cls.is_jump) begin
            take = (dec_op == OP_JMP)
                || ((dec_op == OP_JZ) && bus.z_flag)
                || ((dec_op == OP_JC) && bus.c_flag);
            bus.pc_load = take;
            bus.pc_inc  = !take;
          end else begin
            bus.pc_inc = 1'b1;
            if (dec_op == OP_STA) begin
              bus.mem_wr       = 1'b1;
              bus.mem_addr_sel = SEL_IR;
            end
            if (dec_op == OP_OUT) bus.out_load = 1'b1;
          end
        end
        ST_HALT: bus.halted = 1'b1;
        default: state_next = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: directed programs push hand-computed strobe events with their
// cycle numbers; a negedge monitor pops and compares whenever the DUT strobes.
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] mem [16];
  logic [3:0] pc;
  logic [7:0] rdata;
  int         tests;
  int         fails;
  int         cyc;
  int         exp_halt;
  bit         active;

  // ctl bit layout: rd wr sel[1:0] inc skip load acc_load acc_src alu_sub out_load
  localparam logic [10:0] RD   = 11'h400;
  localparam logic [10:0] WR   = 11'h200;
  localparam logic [10:0] SIR  = 11'h100;
  localparam logic [10:0] SP1  = 11'h080;
  localparam logic [10:0] INC  = 11'h040;
  localparam logic [10:0] SKIP = 11'h020;
  localparam logic [10:0] LD   = 11'h010;
  localparam logic [10:0] AL   = 11'h008;
  localparam logic [10:0] AS   = 11'h004;
  localparam logic [10:0] SUB  = 11'h002;
  localparam logic [10:0] OL   = 11'h001;

  typedef struct {
    int          cyc;
    logic [10:0] ctl;
    logic [3:0]  addr;
    logic [3:0]  tgt;
  } ev_t;

  ev_t sb[$];

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ctl_now();
    return {bus.mem_rd, bus.mem_wr, bus.mem_addr_sel, bus.pc_inc, bus.pc_skip,
            bus.pc_load, bus.acc_load, bus.acc_src, bus.alu_sub, bus.out_load};
  endfunction

  function automatic logic [3:0] addr_now();
    case (bus.mem_addr_sel)
      2'd1:    return pc + 4'd1;
      2'd2:    return bus.ir[3:0];
      default: return pc;
    endcase
  endfunction

  // Memory and PC environment so the DUT sees realistic read data.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      rdata <= '0;
    end else begin
      if (bus.mem_rd)       rdata <= mem[addr_now()];
      if (bus.pc_inc)       pc <= pc + 4'd1;
      else if (bus.pc_skip) pc <= pc + 4'd2;
      else if (bus.pc_load) pc <= bus.pc_data;
    end
  end

  assign bus.mem_rdata = rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ev(input int c, input logic [10:0] ctl,
                    input logic [3:0] addr = 4'h0, input logic [3:0] tgt = 4'h0);
    ev_t e;
    e.cyc  = c;
    e.ctl  = ctl;
    e.addr = addr;
    e.tgt  = tgt;
    sb.push_back(e);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  // Runs k cycles from reset release; run drops/rises after the given edges.
  task automatic run_test(input int k, input int drop, input int raise_c, input int halt_from);
    @(negedge clk);
    check("rst_ctl", {21'd0, ctl_now()}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_ir", {24'd0, bus.ir}, 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cyc      = 0;
    exp_halt = halt_from;
    active   = 1'b1;
    for (int i = 1; i <= k; i++) begin
      @(posedge clk);
      #1;
      if (i == drop)    bus.run = 1'b0;
      if (i == raise_c) bus.run = 1'b1;
    end
    active = 1'b0;
    check("sb_drained", sb.size(), 32'd0);
    sb.delete();
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (active) begin
      logic [10:0] a;
      ev_t         e;
      a = ctl_now();
      check("halted", {31'd0, bus.halted}, {31'd0, (exp_halt >= 0 && cyc >= exp_halt)});
      if (a != '0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got ctl %03h expected none (cycle %0d)", a, cyc);
        end else begin
          e = sb.pop_front();
          check("ev_cycle", cyc, e.cyc);
          check("ev_ctl", {21'd0, a}, {21'd0, e.ctl});
          if (e.ctl[10] || e.ctl[9]) check("ev_addr", {28'd0, addr_now()}, {28'd0, e.addr});
          if (e.ctl[4])              check("ev_pc_data", {28'd0, bus.pc_data}, {28'd0, e.tgt});
        end
      end
      cyc++;
    end
  end

  initial begin
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    exp_halt = -1;
    active   = 1'b0;
    reset    = 1'b1;
    bus.run    = 1'b1;
    bus.z_flag = 1'b0;
    bus.c_flag = 1'b0;
    clr_mem();
    repeat (2) @(posedge clk);

    // NOP stream: 3-cycle instructions, PC advances in EXEC.
    ev(0, RD, 4'h0); ev(2, INC); ev(3, RD, 4'h1); ev(5, INC);
    run_test(6, -1, -1, -1);

    // LDI with immediate at PC+1, then fetch from PC=2.
    clr_mem(); mem[0] = 8'h5A; mem[1] = 8'h3C;
    ev(0, RD, 4'h0); ev(2, RD | SP1, 4'h1); ev(3, AL | AS | SKIP); ev(4, RD, 4'h2);
    run_test(5, -1, -1, -1);

    // ADD then SUB from address 7.
    clr_mem(); mem[0] = 8'h27; mem[1] = 8'h37; mem[7] = 8'h11;
    ev(0, RD, 4'h0); ev(2, RD | SIR, 4'h7); ev(3, AL | INC);
    ev(4, RD, 4'h1); ev(6, RD | SIR, 4'h7); ev(7, AL | SUB | INC); ev(8, RD, 4'h2);
    run_test(9, -1, -1, -1);

    // Conditional jumps, taken and not taken, with the other flag opposite.
    clr_mem(); mem[0] = 8'h7B; bus.z_flag = 1'b1; bus.c_flag = 1'b0;
    ev(0, RD, 4'h0); ev(2, LD, 4'h0, 4'hB); ev(3, RD, 4'hB);
    run_test(4, -1, -1, -1);
    bus.z_flag = 1'b0; bus.c_flag = 1'b1;
    ev(0, RD, 4'h0); ev(2, INC); ev(3, RD, 4'h1);
    run_test(4, -1, -1, -1);
    clr_mem(); mem[0] = 8'h8B; bus.z_flag = 1'b0; bus.c_flag = 1'b1;
    ev(0, RD, 4'h0); ev(2, LD, 4'h0, 4'hB); ev(3, RD, 4'hB);
    run_test(4, -1, -1, -1);
    bus.z_flag = 1'b1; bus.c_flag = 1'b0;
    ev(0, RD, 4'h0); ev(2, INC); ev(3, RD, 4'h1);
    run_test(4, -1, -1, -1);
    bus.z_flag = 1'b0; bus.c_flag = 1'b0;

    // STA, OUT, JMP, then an undefined opcode executing as NOP.
    clr_mem(); mem[0] = 8'h49; mem[1] = 8'hE0; mem[2] = 8'h65; mem[5] = 8'hD3;
    ev(0, RD, 4'h0); ev(2, WR | SIR | INC, 4'h9); ev(3, RD, 4'h1); ev(5, OL | INC);
    ev(6, RD, 4'h2); ev(8, LD, 4'h0, 4'h5); ev(9, RD, 4'h5); ev(11, INC); ev(12, RD, 4'h6);
    run_test(13, -1, -1, -1);

    // LDI at address F: immediate wraps to address 0, next fetch at 1.
    clr_mem(); mem[0] = 8'h6F; mem[15] = 8'h5A;
    ev(0, RD, 4'h0); ev(2, LD, 4'h0, 4'hF); ev(3, RD, 4'hF);
    ev(5, RD | SP1, 4'h0); ev(6, AL | AS | SKIP); ev(7, RD, 4'h1);
    run_test(8, -1, -1, -1);

    // HLT: halted from cycle 2, silent for 20 cycles even with run toggling.
    clr_mem(); mem[0] = 8'hF0;
    ev(0, RD, 4'h0);
    run_test(22, 5, 10, 2);

    // run low out of reset: no fetch at all.
    clr_mem(); bus.run = 1'b0;
    run_test(5, -1, -1, -1);

    // run dropped during MEM of LDA: instruction completes, then waits for run.
    clr_mem(); mem[0] = 8'h17; bus.run = 1'b1;
    ev(0, RD, 4'h0); ev(2, RD | SIR, 4'h7); ev(3, AL | AS | INC); ev(8, RD, 4'h1);
    run_test(9, 2, 8, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
